// File: rtl/scene_sequencer.sv
// Frame-synchronous scene sequencer: picks the active background set, runs a
// fade-out / swap / fade-in around every scene change and issues respawn data.
module scene_sequencer #(
   parameter int unsigned FRAMES_PER_STEP = 2,
   parameter int unsigned DOOR_HOLD       = 4
) (
   input  logic       vga_clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic [1:0] color_main,
   output logic [2:0] scene,
   output logic [3:0] bright,
   output logic [9:0] spawn_x,
   output logic [9:0] spawn_y,
   output logic       spawn_load,
   output logic       busy
);

   localparam int unsigned HOLD_W = $clog2(DOOR_HOLD + 1);
   localparam int unsigned STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   localparam logic [7:0] KEY_ENTER = 8'h28;

   localparam logic [2:0] SC_TITLE = 3'd0;
   localparam logic [2:0] SC_MAIN  = 3'd1;
   localparam logic [2:0] SC_LEFT  = 3'd2;
   localparam logic [2:0] SC_RIGHT = 3'd3;
   localparam logic [2:0] SC_UP    = 3'd4;

   localparam logic [1:0] DOOR_NONE  = 2'b00;
   localparam logic [1:0] DOOR_LEFT  = 2'b01;
   localparam logic [1:0] DOOR_RIGHT = 2'b10;

   typedef enum logic [2:0] {
      ST_TITLE,
      ST_PLAY,
      ST_FADE_OUT,
      ST_SWAP,
      ST_FADE_IN
   } state_t;

   state_t              state;
   logic [2:0]          target;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [1:0]          last_code;
   logic [STEP_W-1:0]   step_cnt;

   logic [HOLD_W-1:0]   hold_next;
   logic                door_hit;
   logic [2:0]          door_target;
   logic                step_done;
   logic [9:0]          next_spawn_x;
   logic [9:0]          next_spawn_y;

   // Door qualification: how long the tick-sampled door code has been stable
   always_comb begin
      hold_next   = '0;
      door_target = SC_MAIN;
      if ((color_main != DOOR_NONE) && (color_main == last_code)) begin
         hold_next = HOLD_W'(hold_cnt + HOLD_W'(1));
      end else if (color_main != DOOR_NONE) begin
         hold_next = HOLD_W'(1);
      end
      door_hit = (hold_next == HOLD_W'(DOOR_HOLD));
      if (scene == SC_MAIN) begin
         case (color_main)
            DOOR_LEFT:  door_target = SC_LEFT;
            DOOR_RIGHT: door_target = SC_RIGHT;
            default:    door_target = SC_UP;
         endcase
      end
      step_done = (step_cnt == STEP_W'(FRAMES_PER_STEP - 1));
   end

   // Respawn point: the player reappears on the side opposite the door used
   always_comb begin
      next_spawn_x = 10'd320;
      next_spawn_y = 10'd240;
      case (target)
         SC_MAIN: begin
            case (scene)
               SC_LEFT:  next_spawn_x = 10'd40;
               SC_RIGHT: next_spawn_x = 10'd600;
               SC_UP:    next_spawn_y = 10'd40;
               default:  next_spawn_x = 10'd320;
            endcase
         end
         SC_LEFT:  next_spawn_x = 10'd600;
         SC_RIGHT: next_spawn_x = 10'd40;
         SC_UP:    next_spawn_y = 10'd440;
         default:  next_spawn_x = 10'd320;
      endcase
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge vga_clk) begin
      if (!Reset) begin
         state      <= ST_TITLE;
         scene      <= SC_TITLE;
         bright     <= 4'd15;
         spawn_x    <= 10'd320;
         spawn_y    <= 10'd240;
         spawn_load <= 1'b0;
         busy       <= 1'b0;
         target     <= SC_TITLE;
         hold_cnt   <= '0;
         last_code  <= DOOR_NONE;
         step_cnt   <= '0;
      end else begin
         spawn_load <= 1'b0;
         case (state)
            ST_TITLE: begin
               if (keycode == KEY_ENTER) begin
                  target   <= SC_MAIN;
                  step_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= ST_FADE_OUT;
               end
            end
            ST_PLAY: begin
               if (frame_tick) begin
                  last_code <= color_main;
                  hold_cnt  <= hold_next;
                  if (door_hit) begin
                     target   <= door_target;
                     step_cnt <= '0;
                     busy     <= 1'b1;
                     state    <= ST_FADE_OUT;
                  end
               end
            end
            ST_FADE_OUT: begin
               if (frame_tick) begin
                  if (step_done) begin
                     step_cnt <= '0;
                     bright   <= bright - 4'd1;
                     if (bright == 4'd1) begin
                        state <= ST_SWAP;
                     end
                  end else begin
                     step_cnt <= STEP_W'(step_cnt + STEP_W'(1));
                  end
               end
            end
            ST_SWAP: begin
               scene      <= target;
               spawn_x    <= next_spawn_x;
               spawn_y    <= next_spawn_y;
               spawn_load <= 1'b1;
               hold_cnt   <= '0;
               last_code  <= DOOR_NONE;
               step_cnt   <= '0;
               state      <= ST_FADE_IN;
            end
            ST_FADE_IN: begin
               if (frame_tick) begin
                  if (step_done) begin
                     step_cnt <= '0;
                     bright   <= bright + 4'd1;
                     if (bright == 4'd14) begin
                        busy  <= 1'b0;
                        state <= ST_PLAY;
                     end
                  end else begin
                     step_cnt <= STEP_W'(step_cnt + STEP_W'(1));
                  end
               end
            end
            default: begin
               state <= ST_TITLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scene_sequencer.sv
// Randomised bench for scene_sequencer against a frame-count reference model.
module tb_scene_sequencer;

   localparam int FPS         = 2;
   localparam int HOLD        = 4;
   localparam int TICK_PERIOD = 4;
   localparam int FADE_TICKS  = 15 * FPS;

   logic       vga_clk = 1'b0;
   logic       Reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic [1:0] color_main = 2'b00;
   logic [2:0] scene;
   logic [3:0] bright;
   logic [9:0] spawn_x;
   logic [9:0] spawn_y;
   logic       spawn_load;
   logic       busy;

   scene_sequencer #(.FRAMES_PER_STEP(FPS), .DOOR_HOLD(HOLD)) dut (
      .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick),
      .keycode(keycode), .color_main(color_main), .scene(scene),
      .bright(bright), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .spawn_load(spawn_load), .busy(busy)
   );

   always #5 vga_clk = ~vga_clk;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 title, 1 play, 2 fade-out, 3 swap, 4 fade-in
   int m_mode, m_scene, m_target, m_ticks, m_hold, m_last, m_sx, m_sy, m_load;

   int cyc = 0;
   int loads = 0;
   int busy_seen = 0;
   int fo_ticks = 0;
   bit fo_open = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int model_bright();
      case (m_mode)
         2:       return 15 - m_ticks / FPS;
         3:       return 0;
         4:       return m_ticks / FPS;
         default: return 15;
      endcase
   endfunction

   task automatic model_edge(input bit rst, input bit tick, input int key, input int code);
      if (!rst) begin
         m_mode = 0; m_scene = 0; m_target = 0; m_ticks = 0;
         m_hold = 0; m_last = 0; m_sx = 320; m_sy = 240; m_load = 0;
         return;
      end
      m_load = 0;
      case (m_mode)
         0: if (key == 'h28) begin m_target = 1; m_ticks = 0; m_mode = 2; end
         1: if (tick) begin
               if (code != 0 && code == m_last) m_hold = m_hold + 1;
               else m_hold = (code != 0) ? 1 : 0;
               m_last = code;
               if (m_hold == HOLD) begin
                  m_target = (m_scene == 1) ? code + 1 : 1;
                  m_ticks = 0;
                  m_mode = 2;
               end
            end
         2: if (tick) begin
               m_ticks++;
               if (m_ticks == FADE_TICKS) m_mode = 3;
            end
         3: begin
               m_sx = 320; m_sy = 240;
               if (m_target == 1) begin
                  if (m_scene == 2) m_sx = 40;
                  else if (m_scene == 3) m_sx = 600;
                  else if (m_scene == 4) m_sy = 40;
               end else if (m_target == 2) m_sx = 600;
               else if (m_target == 3) m_sx = 40;
               else m_sy = 440;
               m_scene = m_target;
               m_load = 1;
               m_hold = 0; m_last = 0; m_ticks = 0;
               m_mode = 4;
            end
         default: if (tick) begin
               m_ticks++;
               if (m_ticks == FADE_TICKS) m_mode = 1;
            end
      endcase
   endtask

   // one clock: drive, advance model on the edge, compare just after it
   task automatic step(input bit rst, input logic [7:0] key, input logic [1:0] code);
      bit pre_busy;
      Reset = rst;
      keycode = key;
      color_main = code;
      frame_tick = (cyc % TICK_PERIOD == 0);
      pre_busy = busy;
      if (fo_open && pre_busy && frame_tick) fo_ticks++;
      @(posedge vga_clk);
      model_edge(rst, frame_tick, int'(key), int'(code));
      cyc++;
      #1;
      if (busy && !pre_busy) begin fo_open = 1; fo_ticks = 0; end
      if (spawn_load) begin loads++; fo_open = 0; end
      if (busy) busy_seen++;
      check("scene", 32'(scene), 32'(m_scene));
      check("bright", 32'(bright), 32'(model_bright()));
      check("busy", 32'(busy), 32'((m_mode >= 2) ? 1 : 0));
      check("spawn_load", 32'(spawn_load), 32'(m_load));
      check("spawn_x", 32'(spawn_x), 32'(m_sx));
      check("spawn_y", 32'(spawn_y), 32'(m_sy));
   endtask

   task automatic run_frames(input int n, input logic [7:0] key, input logic [1:0] code);
      for (int i = 0; i < n * TICK_PERIOD; i++) step(1'b1, key, code);
   endtask

   task automatic wait_play();
      int n = 0;
      while (busy && n < 2000) begin
         step(1'b1, 8'h00, 2'b00);
         n++;
      end
      check("settle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [1:0] cur_code;
      logic [7:0] k;
      int n;

      for (int i = 0; i < 3; i++) step(1'b0, 8'h28, 2'b11);
      check("rst_scene", 32'(scene), 32'd0);
      check("rst_bright", 32'(bright), 32'd15);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_spawn_x", 32'(spawn_x), 32'd320);
      check("rst_spawn_y", 32'(spawn_y), 32'd240);

      // idle in title: random non-Enter keys and door codes are ignored
      loads = 0;
      for (int i = 0; i < 10 * TICK_PERIOD; i++) begin
         k = 8'($urandom_range(0, 255));
         if (k == 8'h28) k = 8'h29;
         step(1'b1, k, 2'($urandom));
      end
      check("idle_loads", 32'(loads), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Enter: busy at the next edge, 30 fade-out ticks, one load pulse
      step(1'b1, 8'h28, 2'b00);
      check("enter_busy", 32'(busy), 32'd1);
      wait_play();
      check("title_main_scene", 32'(scene), 32'd1);
      check("title_main_x", 32'(spawn_x), 32'd320);
      check("title_main_y", 32'(spawn_y), 32'd240);
      check("title_main_loads", 32'(loads), 32'd1);
      check("fade_out_ticks", 32'(fo_ticks), 32'd30);
      check("title_main_bright", 32'(bright), 32'd15);

      // door held only three ticks: nothing happens
      busy_seen = 0;
      run_frames(3, 8'h00, 2'b01);
      run_frames(5, 8'h00, 2'b00);
      check("short_hold_busy", 32'(busy_seen), 32'd0);

      // left door held four ticks
      run_frames(5, 8'h00, 2'b01);
      wait_play();
      check("main_left_scene", 32'(scene), 32'd2);
      check("main_left_x", 32'(spawn_x), 32'd600);
      check("main_left_y", 32'(spawn_y), 32'd240);

      // any door back to main from the left room
      run_frames(5, 8'h00, 2'b01);
      wait_play();
      check("left_main_scene", 32'(scene), 32'd1);
      check("left_main_x", 32'(spawn_x), 32'd40);

      // alternating doors and Enter in play never trigger
      busy_seen = 0;
      for (int i = 0; i < 20; i++) run_frames(1, 8'h28, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("alt_busy", 32'(busy_seen), 32'd0);
      check("alt_scene", 32'(scene), 32'd1);

      // reset in the middle of a fade-out
      run_frames(5, 8'h00, 2'b11);
      n = 0;
      while (!(busy && bright == 4'd7) && n < 1000) begin
         step(1'b1, 8'h00, 2'b00);
         n++;
      end
      check("mid_fade_reached", 32'(bright), 32'd7);
      step(1'b0, 8'h00, 2'b00);
      check("mid_rst_bright", 32'(bright), 32'd15);
      check("mid_rst_scene", 32'(scene), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      run_frames(2, 8'h00, 2'b11);
      check("mid_rst_title_hold", 32'(busy), 32'd0);

      // random traffic with between-tick glitches and occasional resets
      cur_code = 2'b00;
      for (int i = 0; i < 9000; i++) begin
         logic [1:0] c;
         bit r;
         if (cyc % TICK_PERIOD == 0) begin
            if ($urandom_range(0, 3) == 0) cur_code = 2'($urandom);
            c = cur_code;
         end else begin
            c = ($urandom_range(0, 1) == 0) ? 2'($urandom) : cur_code;
         end
         k = ($urandom_range(0, 30) == 0) ? 8'h28 : 8'($urandom_range(0, 255));
         r = ($urandom_range(0, 1499) != 0);
         step(r, k, c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
